mux_n_1_scan: RTL and testbench

- Parametrised N-channel, W-bit registered multiplexer with a built-in channel scanner.
- Manual mode: output follows an externally driven select.
- Scan mode: an internal sequencer steps through all channels round-robin, holding each for a programmable dwell time, and flags each wrap.
- Replaces the fixed 4:1 one-bit mux wherever time-multiplexed channel observation is needed.

---
 rtl/mux_n_1_scan.sv | 108 ++++++++++
 tb/tb_mux_n_1_scan.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_n_1_scan.sv
// N-channel registered mux with manual select or round-robin scan; Q lags its index by one clock.
// Latency 1 clock from sel/channel to Q; no backpressure, the scan advances only on en.
module mux_n_1_scan #(
   parameter int N_CH    = 4,
   parameter int DATA_W  = 1,
   parameter int SEL_W   = 2,
   parameter int DWELL_W = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [N_CH*DATA_W-1:0]   channel,
   input  logic [SEL_W-1:0]         sel,
   input  logic                     mode,
   input  logic                     en,
   input  logic [DWELL_W-1:0]       dwell,
   output logic [DATA_W-1:0]        Q,
   output logic [SEL_W-1:0]         cur_sel,
   output logic                     wrap,
   output logic                     valid
);

   typedef enum logic {MANUAL = 1'b0, SCAN = 1'b1} state_t;

   localparam logic [SEL_W:0]   N_CH_X  = (SEL_W+1)'(N_CH);
   localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

   state_t               state_q, state_d;
   logic [SEL_W-1:0]     cur_sel_q, cur_sel_d;
   logic [DWELL_W-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0]    q_q, q_d;
   logic                 wrap_q, wrap_d;
   logic                 valid_q, valid_d;

   logic                 sel_ok;
   logic [SEL_W-1:0]     rd_idx;
   logic [DATA_W-1:0]    rd_dat;

   assign sel_ok = {1'b0, sel} < N_CH_X;

   // Manual cycles, scan entry and scan exit all read from sel; an out-of-range
   // start index falls back to channel 0 only when entering the scan.
   always_comb begin
      rd_idx = cur_sel_q;
      if (state_q == MANUAL || !mode) begin
         rd_idx = (mode && !sel_ok) ? '0 : sel;
      end
   end

   always_comb begin
      rd_dat = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (rd_idx == SEL_W'(k)) begin
            rd_dat = channel[k*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      state_d   = mode ? SCAN : MANUAL;
      cur_sel_d = cur_sel_q;
      cnt_d     = cnt_q;
      q_d       = rd_dat;
      wrap_d    = 1'b0;
      valid_d   = 1'b1;
      if (state_q == MANUAL || !mode) begin
         cur_sel_d = rd_idx;
         cnt_d     = '0;
         valid_d   = mode | sel_ok;
      end else if (en) begin
         // >= rather than == so a dwell lowered below the running count advances at once.
         if (cnt_q >= dwell) begin
            cnt_d = '0;
            if (cur_sel_q == LAST_CH) begin
               cur_sel_d = '0;
               wrap_d    = 1'b1;
            end else begin
               cur_sel_d = cur_sel_q + SEL_W'(1);
            end
         end else begin
            cnt_d = cnt_q + DWELL_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= MANUAL;
         cur_sel_q <= '0;
         cnt_q     <= '0;
         q_q       <= '0;
         wrap_q    <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cur_sel_q <= cur_sel_d;
         cnt_q     <= cnt_d;
         q_q       <= q_d;
         wrap_q    <= wrap_d;
         valid_q   <= valid_d;
      end
   end

   assign Q       = q_q;
   assign cur_sel = cur_sel_q;
   assign wrap    = wrap_q;
   assign valid   = valid_q;

endmodule

// File: tb/tb_mux_n_1_scan.sv
// Bench for mux_n_1_scan: directed steps plus randomized scan traffic against a cycle model.
module tb_mux_n_1_scan;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   // 4 x 8-bit instance, checked every cycle against the model
   logic [31:0] ch8;
   logic [1:0]  sel8, cs8;
   logic        mode8, en8, wr8, vl8;
   logic [7:0]  dw8, q8;

   // 4 x 1-bit instance
   logic [3:0]  ch1;
   logic [1:0]  sel1, cs1;
   logic        mode1, en1, wr1, vl1;
   logic [7:0]  dw1;
   logic [0:0]  q1;

   // 3 x 1-bit instance
   logic [2:0]  ch3;
   logic [1:0]  sel3, cs3;
   logic        mode3, en3, wr3, vl3;
   logic [7:0]  dw3;
   logic [0:0]  q3;

   mux_n_1_scan #(.N_CH(4), .DATA_W(8), .SEL_W(2), .DWELL_W(8)) u8 (
      .clk(clk), .reset_n(reset_n), .channel(ch8), .sel(sel8), .mode(mode8), .en(en8),
      .dwell(dw8), .Q(q8), .cur_sel(cs8), .wrap(wr8), .valid(vl8));

   mux_n_1_scan #(.N_CH(4), .DATA_W(1), .SEL_W(2), .DWELL_W(8)) u1 (
      .clk(clk), .reset_n(reset_n), .channel(ch1), .sel(sel1), .mode(mode1), .en(en1),
      .dwell(dw1), .Q(q1), .cur_sel(cs1), .wrap(wr1), .valid(vl1));

   mux_n_1_scan #(.N_CH(3), .DATA_W(1), .SEL_W(2), .DWELL_W(8)) u3 (
      .clk(clk), .reset_n(reset_n), .channel(ch3), .sel(sel3), .mode(mode3), .en(en3),
      .dwell(dw3), .Q(q3), .cur_sel(cs3), .wrap(wr3), .valid(vl3));

   int tests = 0;
   int fails = 0;

   // Reference state for u8: scanning flag, index, dwell count and expected outputs.
   int m_scan, m_cur, m_cnt, m_q, m_wrap, m_valid;

   int sq5[5]    = '{0, 1, 2, 3, 0};
   int exp5[5]   = '{1, 0, 1, 0, 1};
   int expa[4]   = '{0, 1, 0, 1};
   int cs_tab[13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
   int q_tab[13]  = '{'h11, 'h11, 'h11, 'h11, 'h22, 'h22, 'h22, 'h33, 'h33, 'h33, 'h44, 'h44, 'h44};
   int u3_tab[4]  = '{0, 1, 2, 0};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int chan8(input int idx);
      return int'((ch8 >> (idx * 8)) & 32'hFF);
   endfunction

   task automatic model_rst();
      m_scan = 0; m_cur = 0; m_cnt = 0; m_q = 0; m_wrap = 0; m_valid = 0;
   endtask

   // One clock of behaviour, from the inputs present just before the edge.
   task automatic model_clk();
      m_wrap = 0;
      if (mode8 && !m_scan) begin
         m_scan  = 1;
         m_cur   = (int'(sel8) < 4) ? int'(sel8) : 0;
         m_cnt   = 0;
         m_q     = chan8(m_cur);
         m_valid = 1;
      end else if (!mode8) begin
         m_scan  = 0;
         m_cur   = int'(sel8);
         m_cnt   = 0;
         m_q     = (m_cur < 4) ? chan8(m_cur) : 0;
         m_valid = (m_cur < 4) ? 1 : 0;
      end else begin
         m_q     = chan8(m_cur);
         m_valid = 1;
         if (en8) begin
            if (m_cnt >= int'(dw8)) begin
               m_cnt  = 0;
               m_wrap = (m_cur == 3) ? 1 : 0;
               m_cur  = (m_cur + 1) % 4;
            end else begin
               m_cnt = m_cnt + 1;
            end
         end
      end
   endtask

   task automatic step();
      model_clk();
      @(posedge clk);
      #1;
      check("q8", {24'd0, q8}, m_q);
      check("cur_sel8", {30'd0, cs8}, m_cur);
      check("wrap8", {31'd0, wr8}, m_wrap);
      check("valid8", {31'd0, vl8}, m_valid);
   endtask

   initial begin
      int wraps;
      reset_n = 1'b1;
      ch8 = '0; sel8 = '0; mode8 = 1'b0; en8 = 1'b0; dw8 = '0;
      ch1 = '0; sel1 = '0; mode1 = 1'b0; en1 = 1'b0; dw1 = '0;
      ch3 = '0; sel3 = '0; mode3 = 1'b0; en3 = 1'b0; dw3 = '0;
      #1 reset_n = 1'b0;
      #1;
      model_rst();
      check("rst_q8", {24'd0, q8}, 0);
      check("rst_cs8", {30'd0, cs8}, 0);
      check("rst_wrap8", {31'd0, wr8}, 0);
      check("rst_valid8", {31'd0, vl8}, 0);
      check("rst_q1", {31'd0, q1}, 0);
      check("rst_valid1", {31'd0, vl1}, 0);
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b1;

      // Manual mode, channel = 4'h5
      ch1 = 4'h5;
      for (int i = 0; i < 5; i++) begin
         sel1 = sq5[i][1:0];
         #1 check("man5_latency", {31'd0, q1}, (i == 0) ? 0 : exp5[i-1]);
         step();
         check("man5_q", {31'd0, q1}, exp5[i]);
         check("man5_valid", {31'd0, vl1}, 1);
         repeat (4) step();
         check("man5_hold", {31'd0, q1}, exp5[i]);
      end

      // Manual mode, channel = 4'hA
      ch1 = 4'hA;
      for (int i = 0; i < 4; i++) begin
         sel1 = 2'(i);
         step();
         check("manA_q", {31'd0, q1}, expa[i]);
         check("manA_cur_sel", {30'd0, cs1}, i);
      end

      // Three channels: index 3 is out of range
      ch3 = 3'b111; sel3 = 2'd3;
      step();
      check("n3_q_oor", {31'd0, q3}, 0);
      check("n3_valid_oor", {31'd0, vl3}, 0);
      sel3 = 2'd2;
      step();
      check("n3_q_in", {31'd0, q3}, 1);
      check("n3_valid_in", {31'd0, vl3}, 1);
      sel3 = 2'd3; dw3 = 8'd0; en3 = 1'b1; mode3 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("n3_scan_cur_sel", {30'd0, cs3}, u3_tab[i]);
         check("n3_scan_wrap", {31'd0, wr3}, (i == 3) ? 1 : 0);
      end

      // Scan with dwell = 2
      ch8 = 32'h44332211; sel8 = 2'd0; dw8 = 8'd2; en8 = 1'b1; mode8 = 1'b0;
      step();
      mode8 = 1'b1;
      for (int i = 0; i < 13; i++) begin
         step();
         check("scan_cur_sel", {30'd0, cs8}, cs_tab[i]);
         check("scan_q", {24'd0, q8}, q_tab[i]);
         check("scan_wrap", {31'd0, wr8}, (i == 12) ? 1 : 0);
      end

      // en low mid-dwell freezes the hold
      step();
      en8 = 1'b0;
      repeat (4) begin
         step();
         check("freeze_cur_sel", {30'd0, cs8}, 0);
      end
      en8 = 1'b1;
      step();
      check("resume_hold", {30'd0, cs8}, 0);
      step();
      check("resume_adv", {30'd0, cs8}, 1);

      // Dwell lowered below the running count advances on the next cycle
      dw8 = 8'd5;
      repeat (4) step();
      dw8 = 8'd2;
      step();
      check("dwell_drop_adv", {30'd0, cs8}, 2);

      // dwell = 0 advances every cycle
      dw8 = 8'd0;
      wraps = 0;
      repeat (8) begin
         step();
         wraps += int'(wr8);
      end
      check("dwell0_wraps", wraps, 2);

      // Async reset mid-scan at cur_sel = 2
      check("pre_rst_cur_sel", {30'd0, cs8}, 2);
      reset_n = 1'b0;
      #1;
      check("arst_q", {24'd0, q8}, 0);
      check("arst_cur_sel", {30'd0, cs8}, 0);
      check("arst_wrap", {31'd0, wr8}, 0);
      check("arst_valid", {31'd0, vl8}, 0);
      model_rst();
      @(posedge clk);
      #1 check("arst_hold_valid", {31'd0, vl8}, 0);
      #2 reset_n = 1'b1;
      sel8 = 2'd1;
      step();
      check("rst_entry_cur_sel", {30'd0, cs8}, 1);
      check("rst_entry_q", {24'd0, q8}, 'h22);

      // Randomized traffic against the model
      repeat (400) begin
         ch8  = $urandom;
         sel8 = 2'($urandom_range(0, 3));
         en8  = ($urandom_range(0, 3) != 0);
         dw8  = 8'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) mode8 = ~mode8;
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
